snn_ram_loader: RTL and testbench
=================================

# snn_ram_loader

Write-side companion to the design's read-only weight and parameter memories. Takes the byte stream from the UART receiver, unpacks each byte LSB-first into single-bit pixel writes, and fills a DEPTH-entry, 1-bit-wide, single-port image RAM. Signals completion so the SNN core can start inference. Also handles restart, overrun and partial final bytes.

## Interface
Parameters:
- ADDR_WIDTH, 10, width of the RAM write address
- DEPTH, 784, number of pixel entries to write (1..2**ADDR_WIDTH)

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  one-cycle pulse; begins (or restarts) a load at address 0
- rx_data  input  8  received byte, valid when rx_rdy=1
- rx_rdy  input  1  one-cycle pulse marking a new byte
- we  output  1  RAM write enable, registered
- waddr  output  ADDR_WIDTH  RAM write address, registered
- wdata  output  1  RAM write data (pixel bit), registered
- busy  output  1  high in WAIT_BYTE and WRITE
- load_done  output  1  high in DONE, cleared by start or reset
- overrun  output  1  sticky; byte arrived while not accepting; cleared by start or reset

## Operation
- State machine: IDLE, WAIT_BYTE, WRITE, DONE.
- IDLE: ignores rx_rdy, with no overrun in this state. start -> WAIT_BYTE with pixel counter = 0.
- WAIT_BYTE: rx_rdy=1 -> latch rx_data into an 8-bit shift register, set bit counter = 0, go to WRITE.
- WRITE: each cycle, drive we=1, waddr=pixel counter, wdata=shift[0].
  - After each write, shift right, increment bit counter and increment pixel counter.
  - If the written address was DEPTH-1 -> DONE; remaining bits of the byte are discarded.
  - Else, after the 8th bit -> WAIT_BYTE.
- DONE: load_done=1; no writes. start -> WAIT_BYTE.
- Overrun: rx_rdy=1 in WRITE or DONE sets overrun=1. The byte is dropped and has no other effect.
- start in any state (including WAIT_BYTE or WRITE):
  - pixel counter = 0, load_done=0, overrun=0, state -> WAIT_BYTE.
  - The byte in progress is abandoned; no write occurs in the start cycle.
- start and rx_rdy in the same cycle: start wins and the byte is dropped. overrun is not set.
- Pixel counter is ADDR_WIDTH+1 bits; it never exceeds DEPTH, so there is no wrap-around.
- Reset values:
  - state=IDLE
  - we=0, waddr=0, wdata=0
  - busy=0, load_done=0, overrun=0
  - all counters 0

## Timing
- rx_rdy sampled at edge N -> we=1 for the 8 cycles following N, addresses base..base+7 ascending, then we=0.
- Throughput: one byte per 9 cycles minimum. A byte arriving on the cycle after the 8th write (state WAIT_BYTE) is accepted. Bytes arriving during the 8 write cycles overrun.
- The last write of a load is in cycle K; load_done=1 and busy=0 from cycle K+1.
- start at edge S -> busy=1 and load_done=0 from S+1; we=0 at S+1.
- rst_n=0 sampled at any edge forces reset values at the next cycle, including mid-WRITE (we drops immediately). Reset has priority over start.
- The RAM captures on posedge clk with we/waddr/wdata as presented; the loader adds no extra latency.

## Test plan
- Reset then start, feed 98 bytes each spaced 20 cycles, byte k = k[7:0]:
  - 784 writes with waddr 0..783; wdata at addr 8k+i = bit i of k.
  - load_done=1 one cycle after the addr-783 write; overrun=0.
- DEPTH=10: feed bytes 0xFF then 0x03 -> writes addr 0..9 all 1; bits 2..7 of the second byte are not written; DONE after the 10th write.
- Byte 0xA5 accepted, second rx_rdy 3 cycles later:
  - writes 1,0,1,0,0,1,0,1 complete unaltered;
  - overrun=1;
  - the next byte, spaced ≥9 cycles after the first, is written at addr 8.
- start pulse during the 4th write of byte 2:
  - we=0 next cycle, busy=1, overrun cleared;
  - the next byte is written starting at addr 0.
- rst_n=0 mid-WRITE: next cycle we=0, busy=0, load_done=0, overrun=0, waddr=0; rx_rdy ignored until start.
- start and rx_rdy in the same cycle from DONE: load_done=0, no write, overrun=0, state WAIT_BYTE.

Source files
------------

// File: rtl/snn_ram_loader.sv
// snn_ram_loader: unpacks received UART bytes LSB-first into single-bit
// writes that fill a DEPTH-entry, 1-bit-wide image RAM, then flags completion.
module snn_ram_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 784
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_rdy,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wdata,
    output logic                  busy,
    output logic                  load_done,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BYTE = 2'd1,
        WRITE     = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] PIX_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] LAST_PIX = (ADDR_WIDTH+1)'(DEPTH - 1);

    state_t                state_q, state_d;
    logic [7:0]            shift_q, shift_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [ADDR_WIDTH:0]   pix_q, pix_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  wdata_q, wdata_d;
    logic                  overrun_q, overrun_d;

    // Next-state and registered-output computation. The write port is
    // registered, so the write for a bit is set up one cycle ahead: accepting
    // a byte presents bit 0 immediately and keeps only bits 7..1 in the shift
    // register, whose bit 0 is then always the next bit to present.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        pix_d     = pix_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        overrun_d = overrun_q;

        if (start) begin
            state_d   = WAIT_BYTE;
            pix_d     = '0;
            bit_cnt_d = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                WAIT_BYTE: begin
                    if (rx_rdy) begin
                        state_d   = WRITE;
                        shift_d   = {1'b0, rx_data[7:1]};
                        bit_cnt_d = '0;
                        we_d      = 1'b1;
                        waddr_d   = pix_q[ADDR_WIDTH-1:0];
                        wdata_d   = rx_data[0];
                    end
                end
                WRITE: begin
                    if (rx_rdy) begin
                        overrun_d = 1'b1;
                    end
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    pix_d     = pix_q + PIX_ONE;
                    if (pix_q == LAST_PIX) begin
                        state_d = DONE;
                    end else if (bit_cnt_q == 3'd7) begin
                        state_d = WAIT_BYTE;
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = pix_d[ADDR_WIDTH-1:0];
                        wdata_d = shift_q[0];
                    end
                end
                DONE: begin
                    if (rx_rdy) begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            pix_q     <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            pix_q     <= pix_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            overrun_q <= overrun_d;
        end
    end

    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign busy      = (state_q == WAIT_BYTE) || (state_q == WRITE);
    assign load_done = (state_q == DONE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_snn_ram_loader.sv
// Testbench for snn_ram_loader: a full-size instance (DEPTH=784) and a small
// instance (DEPTH=10) share clock and reset; expected RAM writes are queued
// per instance and compared as each write appears.
module tb_snn_ram_loader;

    typedef struct {
        logic [9:0] addr;
        logic       data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, rx_rdy_a = 1'b0;
    logic [7:0] rx_data_a = '0;
    logic       we_a, wdata_a, busy_a, load_done_a, overrun_a;
    logic [9:0] waddr_a;
    logic       start_b = 1'b0, rx_rdy_b = 1'b0;
    logic [7:0] rx_data_b = '0;
    logic       we_b, wdata_b, busy_b, load_done_b, overrun_b;
    logic [3:0] waddr_b;

    wr_t qa[$];
    wr_t qb[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  wcnt_a = 0;
    int  wcnt_b = 0;

    always #5 clk = ~clk;

    snn_ram_loader #(.ADDR_WIDTH(10), .DEPTH(784)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .rx_data(rx_data_a),
        .rx_rdy(rx_rdy_a), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
        .busy(busy_a), .load_done(load_done_a), .overrun(overrun_a)
    );

    snn_ram_loader #(.ADDR_WIDTH(4), .DEPTH(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .rx_data(rx_data_b),
        .rx_rdy(rx_rdy_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
        .busy(busy_b), .load_done(load_done_b), .overrun(overrun_b)
    );

    // Advance one cycle; the write port of the current cycle is scored at the
    // falling edge, inputs change 1 ns after the rising edge.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (we_a !== 1'b0) begin
            n_checks++;
            wcnt_a++;
            if (qa.size() == 0) begin
                n_errors++;
                $display("FAIL write_a_unexpected: got we=%b waddr=%0d wdata=%b, expected no write", we_a, waddr_a, wdata_a);
            end else begin
                e = qa.pop_front();
                if (we_a !== 1'b1 || waddr_a !== e.addr || wdata_a !== e.data) begin
                    n_errors++;
                    $display("FAIL write_a: got we=%b waddr=%0d wdata=%b, expected we=1 waddr=%0d wdata=%b",
                             we_a, waddr_a, wdata_a, e.addr, e.data);
                end
            end
        end
        if (we_b !== 1'b0) begin
            n_checks++;
            wcnt_b++;
            if (qb.size() == 0) begin
                n_errors++;
                $display("FAIL write_b_unexpected: got we=%b waddr=%0d wdata=%b, expected no write", we_b, waddr_b, wdata_b);
            end else begin
                e = qb.pop_front();
                if (we_b !== 1'b1 || waddr_b !== e.addr[3:0] || wdata_b !== e.data) begin
                    n_errors++;
                    $display("FAIL write_b: got we=%b waddr=%0d wdata=%b, expected we=1 waddr=%0d wdata=%b",
                             we_b, waddr_b, wdata_b, e.addr[3:0], e.data);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int base, input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) qa.push_back('{addr: 10'(base + i), data: b[i]});
    endtask

    task automatic push_b(input int base, input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) qb.push_back('{addr: 10'(base + i), data: b[i]});
    endtask

    task automatic send_a(input logic [7:0] b);
        rx_data_a = b;
        rx_rdy_a  = 1'b1;
        tick();
        rx_rdy_a  = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        rx_data_b = b;
        rx_rdy_b  = 1'b1;
        tick();
        rx_rdy_b  = 1'b0;
    endtask

    task automatic start_pulse_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tick();
        n_checks++;
        if ({we_a, waddr_a, wdata_a, busy_a, load_done_a, overrun_a} !== 15'b0) begin
            n_errors++;
            $display("FAIL reset_a: got we=%b waddr=%0d wdata=%b busy=%b done=%b ovr=%b, expected all 0",
                     we_a, waddr_a, wdata_a, busy_a, load_done_a, overrun_a);
        end
        n_checks++;
        if ({we_b, waddr_b, wdata_b, busy_b, load_done_b, overrun_b} !== 9'b0) begin
            n_errors++;
            $display("FAIL reset_b: got we=%b waddr=%0d wdata=%b busy=%b done=%b ovr=%b, expected all 0",
                     we_b, waddr_b, wdata_b, busy_b, load_done_b, overrun_b);
        end
        rst_n = 1'b1;
        tick();
        send_a(8'hFF);
        repeat (10) tick();
        n_checks++;
        if ({busy_a, overrun_a, load_done_a} !== 3'b000 || wcnt_a != 0) begin
            n_errors++;
            $display("FAIL idle_ignores_rx: got busy=%b ovr=%b done=%b writes=%0d, expected 0 0 0 0",
                     busy_a, overrun_a, load_done_a, wcnt_a);
        end
    endtask

    task automatic test_full_load();
        wcnt_a = 0;
        start_pulse_a();
        n_checks++;
        if ({busy_a, load_done_a, we_a} !== 3'b100) begin
            n_errors++;
            $display("FAIL start_busy: got busy=%b done=%b we=%b, expected 1 0 0", busy_a, load_done_a, we_a);
        end
        for (int k = 0; k < 98; k++) begin
            logic [7:0] kb;
            kb = k[7:0];
            push_a(8 * k, kb, 8);
            send_a(kb);
            if (k < 97) begin
                repeat (19) tick();
            end else begin
                repeat (7) tick();
                n_checks++;
                if (we_a !== 1'b1 || waddr_a !== 10'd783 || load_done_a !== 1'b0) begin
                    n_errors++;
                    $display("FAIL last_write: got we=%b waddr=%0d done=%b, expected 1 783 0", we_a, waddr_a, load_done_a);
                end
                tick();
                n_checks++;
                if ({load_done_a, busy_a, we_a, overrun_a} !== 4'b1000) begin
                    n_errors++;
                    $display("FAIL done_after_last: got done=%b busy=%b we=%b ovr=%b, expected 1 0 0 0",
                             load_done_a, busy_a, we_a, overrun_a);
                end
            end
        end
        repeat (5) tick();
        n_checks++;
        if (wcnt_a != 784 || qa.size() != 0) begin
            n_errors++;
            $display("FAIL full_load_count: got writes=%0d pending=%0d, expected 784 0", wcnt_a, qa.size());
        end
    endtask

    task automatic test_start_rx_same();
        start_a   = 1'b1;
        rx_rdy_a  = 1'b1;
        rx_data_a = 8'hFF;
        tick();
        start_a  = 1'b0;
        rx_rdy_a = 1'b0;
        n_checks++;
        if ({load_done_a, busy_a, we_a, overrun_a} !== 4'b0100) begin
            n_errors++;
            $display("FAIL start_rx_same: got done=%b busy=%b we=%b ovr=%b, expected 0 1 0 0",
                     load_done_a, busy_a, we_a, overrun_a);
        end
        repeat (5) tick();
        n_checks++;
        if (busy_a !== 1'b1 || qa.size() != 0) begin
            n_errors++;
            $display("FAIL start_rx_same_wait: got busy=%b pending=%0d, expected 1 0", busy_a, qa.size());
        end
    endtask

    task automatic test_back_to_back();
        start_pulse_a();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] b;
            b = 8'h31 + 8'(k * 8'h44);
            push_a(8 * k, b, 8);
            send_a(b);
            repeat (8) tick();
        end
        n_checks++;
        if (overrun_a !== 1'b0 || qa.size() != 0) begin
            n_errors++;
            $display("FAIL back_to_back: got ovr=%b pending=%0d, expected 0 0", overrun_a, qa.size());
        end
        push_a(24, 8'h96, 8);
        send_a(8'h96);
        repeat (7) tick();
        send_a(8'h7E);
        n_checks++;
        if (overrun_a !== 1'b1) begin
            n_errors++;
            $display("FAIL overrun_8th_write: got ovr=%b, expected 1", overrun_a);
        end
        repeat (10) tick();
        n_checks++;
        if (qa.size() != 0 || busy_a !== 1'b1) begin
            n_errors++;
            $display("FAIL dropped_byte: got pending=%0d busy=%b, expected 0 1", qa.size(), busy_a);
        end
    endtask

    task automatic test_overrun();
        start_pulse_a();
        push_a(0, 8'hA5, 8);
        send_a(8'hA5);
        repeat (2) tick();
        send_a(8'h0F);
        n_checks++;
        if (overrun_a !== 1'b1 || we_a !== 1'b1) begin
            n_errors++;
            $display("FAIL overrun_set: got ovr=%b we=%b, expected 1 1", overrun_a, we_a);
        end
        repeat (6) tick();
        push_a(8, 8'h3C, 8);
        send_a(8'h3C);
        repeat (10) tick();
        n_checks++;
        if (qa.size() != 0 || overrun_a !== 1'b1) begin
            n_errors++;
            $display("FAIL overrun_next_byte: got pending=%0d ovr=%b, expected 0 1", qa.size(), overrun_a);
        end
    endtask

    task automatic test_start_mid_write();
        start_pulse_a();
        push_a(0, 8'h11, 8);
        send_a(8'h11);
        repeat (9) tick();
        push_a(8, 8'hC3, 4);
        send_a(8'hC3);
        send_a(8'hEE);
        n_checks++;
        if (overrun_a !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_write_overrun: got ovr=%b, expected 1", overrun_a);
        end
        repeat (2) tick();
        start_pulse_a();
        n_checks++;
        if ({we_a, busy_a, overrun_a, load_done_a} !== 4'b0100) begin
            n_errors++;
            $display("FAIL start_mid_write: got we=%b busy=%b ovr=%b done=%b, expected 0 1 0 0",
                     we_a, busy_a, overrun_a, load_done_a);
        end
        push_a(0, 8'h5A, 8);
        send_a(8'h5A);
        repeat (10) tick();
        n_checks++;
        if (qa.size() != 0) begin
            n_errors++;
            $display("FAIL restart_addr0: got pending=%0d, expected 0", qa.size());
        end
    endtask

    task automatic test_depth10();
        wcnt_b  = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        push_b(0, 8'hFF, 8);
        send_b(8'hFF);
        repeat (9) tick();
        push_b(8, 8'h03, 2);
        send_b(8'h03);
        tick();
        n_checks++;
        if (we_b !== 1'b1 || waddr_b !== 4'd9 || load_done_b !== 1'b0) begin
            n_errors++;
            $display("FAIL d10_last_write: got we=%b waddr=%0d done=%b, expected 1 9 0", we_b, waddr_b, load_done_b);
        end
        tick();
        n_checks++;
        if ({load_done_b, busy_b, we_b} !== 3'b100) begin
            n_errors++;
            $display("FAIL d10_done: got done=%b busy=%b we=%b, expected 1 0 0", load_done_b, busy_b, we_b);
        end
        repeat (10) tick();
        n_checks++;
        if (wcnt_b != 10 || qb.size() != 0) begin
            n_errors++;
            $display("FAIL d10_count: got writes=%0d pending=%0d, expected 10 0", wcnt_b, qb.size());
        end
        send_b(8'h55);
        n_checks++;
        if (overrun_b !== 1'b1 || load_done_b !== 1'b1) begin
            n_errors++;
            $display("FAIL d10_overrun_done: got ovr=%b done=%b, expected 1 1", overrun_b, load_done_b);
        end
    endtask

    task automatic test_reset_mid_write();
        start_pulse_a();
        push_a(0, 8'hFF, 3);
        send_a(8'hFF);
        send_a(8'h00);
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({we_a, busy_a, load_done_a, overrun_a, waddr_a} !== 14'b0) begin
            n_errors++;
            $display("FAIL reset_mid_write: got we=%b busy=%b done=%b ovr=%b waddr=%0d, expected all 0",
                     we_a, busy_a, load_done_a, overrun_a, waddr_a);
        end
        rst_n = 1'b1;
        tick();
        send_a(8'hFF);
        repeat (10) tick();
        n_checks++;
        if ({busy_a, overrun_a, load_done_a} !== 3'b000 || qa.size() != 0) begin
            n_errors++;
            $display("FAIL post_reset_idle: got busy=%b ovr=%b done=%b pending=%0d, expected 0 0 0 0",
                     busy_a, overrun_a, load_done_a, qa.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_start_rx_same();
        test_back_to_back();
        test_overrun();
        test_start_mid_write();
        test_depth10();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
